// File: rtl/opamp_cal_pkg.sv
// Shared types and helpers for the op-amp offset-trim controller.
package opamp_cal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DECIDE = 3'd3,
    ST_STORE  = 3'd4,
    ST_DONE   = 3'd5
  } cal_state_e;

  // Width needed to index n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 32'sd0;
    for (int v = n - 32'sd1; v > 32'sd0; v = v >>> 1) begin
      r = r + 32'sd1;
    end
    return (r < 32'sd1) ? 32'sd1 : r;
  endfunction

  function automatic logic [7:0] midscale(input int bits);
    return 8'd1 << (bits - 32'sd1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-high reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Metastability filter chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/opamp_offset_cal.sv
// SAR offset-trim controller: per channel, binary-searches a trim-DAC code against a
// synchronized comparator, then holds the codes and flags saturated channels.
module opamp_offset_cal
  import opamp_cal_pkg::*;
#(
  parameter  int NUM_CH        = 4,
  parameter  int TRIM_BITS     = 6,
  parameter  int SETTLE_CYCLES = 16,
  localparam int CH_W          = clog2_min1(NUM_CH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [NUM_CH-1:0]             cal_mask,
  input  logic                          cmp_in,
  output logic [CH_W-1:0]               ch_sel,
  output logic                          cal_en,
  output logic [NUM_CH*TRIM_BITS-1:0]   trim_code,
  output logic [NUM_CH-1:0]             sat_flag,
  output logic                          busy,
  output logic                          done
);

  localparam int CNT_W = clog2_min1(SETTLE_CYCLES);
  localparam int BIT_W = clog2_min1(TRIM_BITS);
  localparam logic [TRIM_BITS-1:0] MID      = TRIM_BITS'(midscale(TRIM_BITS));
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CH_W-1:0]      CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [BIT_W-1:0]     BIT_TOP  = BIT_W'(TRIM_BITS - 1);

  cal_state_e                  state_r, state_s;
  logic [CH_W-1:0]             ch_r, ch_s;
  logic [NUM_CH-1:0]           mask_r, mask_s;
  logic [TRIM_BITS-1:0]        work_r, work_s;
  logic [BIT_W-1:0]            bit_idx_r, bit_idx_s;
  logic [CNT_W-1:0]            cnt_r, cnt_s;
  logic [TRIM_BITS-1:0]        trim_r [NUM_CH];
  logic [TRIM_BITS-1:0]        trim_s [NUM_CH];
  logic [NUM_CH-1:0]           sat_r, sat_s;
  logic                        cmp_sync_s;
  logic                        cal_phase_s;
  logic                        busy_r, busy_s;
  logic                        cal_en_r, cal_en_s;
  logic                        done_r, done_s;
  logic [NUM_CH*TRIM_BITS-1:0] trim_code_r, trim_code_s;

  sync_2ff #(.WIDTH(1)) u_cmp_sync (
    .clk (clk),
    .rst (rst),
    .d   (cmp_in),
    .q   (cmp_sync_s)
  );

  // Next-state and datapath updates for the search sequencer
  always_comb begin
    state_s   = state_r;
    ch_s      = ch_r;
    mask_s    = mask_r;
    work_s    = work_r;
    bit_idx_s = bit_idx_r;
    cnt_s     = cnt_r;
    trim_s    = trim_r;
    sat_s     = sat_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !abort) begin
          mask_s  = cal_mask;
          ch_s    = {CH_W{1'b0}};
          state_s = ST_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (mask_r[ch_r]) begin
          work_s    = MID;
          bit_idx_s = BIT_TOP;
          cnt_s     = {CNT_W{1'b0}};
          state_s   = ST_SETTLE;
        end else if (ch_r == CH_LAST) begin
          state_s = ST_DONE;
        end else begin
          ch_s    = ch_r + CH_W'(1);
          state_s = ST_SETUP;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == CNT_LAST) begin
          state_s = ST_DECIDE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_DECIDE: begin
        // A positive offset means the trial code overshot: drop the bit under test.
        if (cmp_sync_s) begin
          work_s[bit_idx_r] = 1'b0;
        end else begin
          work_s[bit_idx_r] = work_r[bit_idx_r];
        end
        if (bit_idx_r != {BIT_W{1'b0}}) begin
          work_s[bit_idx_r - BIT_W'(1)] = 1'b1;
          bit_idx_s = bit_idx_r - BIT_W'(1);
          cnt_s     = {CNT_W{1'b0}};
          state_s   = ST_SETTLE;
        end else begin
          state_s = ST_STORE;
        end
      end
      ST_STORE: begin
        trim_s[ch_r] = work_r;
        sat_s[ch_r]  = (work_r == {TRIM_BITS{1'b0}}) || (work_r == {TRIM_BITS{1'b1}});
        if (ch_r == CH_LAST) begin
          state_s = ST_DONE;
        end else begin
          ch_s    = ch_r + CH_W'(1);
          state_s = ST_SETUP;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // Abort discards the channel in flight; anything already stored stays.
    if (abort && (state_r != ST_IDLE)) begin
      state_s = ST_IDLE;
      trim_s  = trim_r;
      sat_s   = sat_r;
    end else begin
      state_s = state_s;
    end
    if (state_s == ST_IDLE) begin
      ch_s = {CH_W{1'b0}};
    end else begin
      ch_s = ch_s;
    end
  end

  // Output values for the coming cycle, so every output leaves a flop
  always_comb begin
    cal_phase_s = (state_s == ST_SETTLE) || (state_s == ST_DECIDE) || (state_s == ST_STORE);
    busy_s      = (state_s != ST_IDLE);
    done_s      = (state_s == ST_DONE);
    cal_en_s    = cal_phase_s || ((state_s == ST_SETUP) && mask_s[ch_s]);
    trim_code_s = {(NUM_CH*TRIM_BITS){1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      if (cal_phase_s && (ch_s == CH_W'(k))) begin
        trim_code_s[k*TRIM_BITS +: TRIM_BITS] = work_s;
      end else begin
        trim_code_s[k*TRIM_BITS +: TRIM_BITS] = trim_s[k];
      end
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ch_r        <= {CH_W{1'b0}};
      mask_r      <= {NUM_CH{1'b0}};
      work_r      <= MID;
      bit_idx_r   <= {BIT_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      sat_r       <= {NUM_CH{1'b0}};
      for (int k = 0; k < NUM_CH; k++) begin
        trim_r[k] <= MID;
      end
      busy_r      <= 1'b0;
      cal_en_r    <= 1'b0;
      done_r      <= 1'b0;
      trim_code_r <= {NUM_CH{MID}};
    end else begin
      state_r     <= state_s;
      ch_r        <= ch_s;
      mask_r      <= mask_s;
      work_r      <= work_s;
      bit_idx_r   <= bit_idx_s;
      cnt_r       <= cnt_s;
      sat_r       <= sat_s;
      trim_r      <= trim_s;
      busy_r      <= busy_s;
      cal_en_r    <= cal_en_s;
      done_r      <= done_s;
      trim_code_r <= trim_code_s;
    end
  end

  assign ch_sel    = ch_r;
  assign cal_en    = cal_en_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign sat_flag  = sat_r;
  assign trim_code = trim_code_r;

endmodule

// File: tb/tb_opamp_offset_cal.sv
// Bench for opamp_offset_cal: a cycle schedule built from the search rules is compared
// against the outputs every cycle, with a few literal expectations on top.
module tb_opamp_offset_cal;

  localparam int NUM_CH = 4;
  localparam int TB     = 6;
  localparam int SC     = 16;
  localparam int SEG    = 2 + TB * (SC + 1);
  localparam int W      = NUM_CH * TB;

  logic clk = 1'b0;
  logic rst, start, abort, cmp_in, cal_en, busy, done;
  logic [NUM_CH-1:0] cal_mask, sat_flag;
  logic [1:0] ch_sel;
  logic [W-1:0] trim_code;

  typedef struct {
    int                ch_sel;
    bit                cal_en;
    bit                busy;
    bit                done;
    logic [W-1:0]      trim;
    logic [NUM_CH-1:0] sat;
    logic [W-1:0]      com_trim;
    logic [NUM_CH-1:0] com_sat;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int ideal [NUM_CH];
  logic [W-1:0] mdl_trim;
  logic [NUM_CH-1:0] mdl_sat;
  bit mdl_busy, abort_pend, chk_en;
  int cyc, start_cyc, done_cyc, n_chk, n_pass;

  always #5 clk = ~clk;

  // Comparator of the selected op-amp: positive offset while the trial code is above ideal.
  assign cmp_in = int'(trim_code[ch_sel*TB +: TB]) > ideal[ch_sel];

  opamp_offset_cal #(.NUM_CH(NUM_CH), .TRIM_BITS(TB), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cal_mask(cal_mask), .cmp_in(cmp_in),
    .ch_sel(ch_sel), .cal_en(cal_en), .trim_code(trim_code), .sat_flag(sat_flag),
    .busy(busy), .done(done)
  );

  function automatic logic [W-1:0] put(input logic [W-1:0] v, input int ch, input int code);
    logic [W-1:0] r;
    r = v;
    r[ch*TB +: TB] = TB'(code);
    return r;
  endfunction

  function automatic exp_t mk(input int chs, input bit cal, input bit bsy, input bit dn,
                              input logic [W-1:0] tr, input logic [NUM_CH-1:0] st,
                              input logic [W-1:0] ct, input logic [NUM_CH-1:0] cs);
    exp_t e;
    e.ch_sel = chs; e.cal_en = cal; e.busy = bsy; e.done = dn;
    e.trim = tr; e.sat = st; e.com_trim = ct; e.com_sat = cs;
    return e;
  endfunction

  // Expected output of every cycle of a run, starting with the cycle after the start edge.
  task automatic build_run(input logic [NUM_CH-1:0] mask);
    logic [W-1:0] ct;
    logic [NUM_CH-1:0] cs;
    int w, trial;
    ct = mdl_trim;
    cs = mdl_sat;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (mask[ch]) begin
        exp_q.push_back(mk(ch, 1'b1, 1'b1, 1'b0, ct, cs, ct, cs));
        w = 0;
        for (int b = TB - 1; b >= 0; b--) begin
          trial = w | (1 << b);
          for (int k = 0; k <= SC; k++) exp_q.push_back(mk(ch, 1'b1, 1'b1, 1'b0, put(ct, ch, trial), cs, ct, cs));
          if (trial <= ideal[ch]) w = trial;
        end
        exp_q.push_back(mk(ch, 1'b1, 1'b1, 1'b0, put(ct, ch, w), cs, ct, cs));
        ct = put(ct, ch, w);
        cs[ch] = (w == 0) || (w == (1 << TB) - 1);
      end else begin
        exp_q.push_back(mk(ch, 1'b0, 1'b1, 1'b0, ct, cs, ct, cs));
      end
    end
    exp_q.push_back(mk(NUM_CH - 1, 1'b0, 1'b1, 1'b1, ct, cs, ct, cs));
  endtask

  // Per-cycle comparison against the schedule (or the idle state once it runs out)
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (chk_en && !rst) begin
      if (abort_pend) begin
        exp_q.delete();
        abort_pend = 1'b0;
      end
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = mk(0, 1'b0, 1'b0, 1'b0, mdl_trim, mdl_sat, mdl_trim, mdl_sat);
      mdl_trim = cur.com_trim;
      mdl_sat  = cur.com_sat;
      mdl_busy = cur.busy;
      if (done === 1'b1) done_cyc = cyc;
      n_chk = n_chk + 1;
      if (ch_sel !== 2'(cur.ch_sel) || cal_en !== cur.cal_en || busy !== cur.busy ||
          done !== cur.done || trim_code !== cur.trim || sat_flag !== cur.sat) begin
        $display("FAIL cycle%0d: got ch_sel=%0d cal_en=%b busy=%b done=%b trim=%h sat=%b, want ch_sel=%0d cal_en=%b busy=%b done=%b trim=%h sat=%b",
                 cyc, ch_sel, cal_en, busy, done, trim_code, sat_flag,
                 cur.ch_sel, cur.cal_en, cur.busy, cur.done, cur.trim, cur.sat);
      end else begin
        n_pass = n_pass + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk = n_chk + 1;
    if (got !== want) $display("FAIL %s: got %0h want %0h", name, got, want);
    else n_pass = n_pass + 1;
  endtask

  task automatic pulse_start(input logic [NUM_CH-1:0] mask, input bit with_abort);
    @(negedge clk);
    start = 1'b1;
    cal_mask = mask;
    abort = with_abort;
    if (with_abort) abort_pend = 1'b1;
    if (!mdl_busy && !with_abort) begin
      build_run(mask);
      start_cyc = cyc + 1;
      done_cyc = -1;
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_chk = n_chk + 1;
    if (n >= budget) begin
      $display("FAIL wait_idle: still busy after %0d cycles", budget);
      exp_q.delete();
    end else begin
      n_pass = n_pass + 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    mdl_trim = {NUM_CH{6'h20}};
    mdl_sat = '0;
    mdl_busy = 1'b0;
    abort_pend = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_cal_en", cal_en, 0);
    check("rst_trim", trim_code, 32'h0082_0820);
    check("rst_sat", sat_flag, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int lat_exp;
    logic [NUM_CH-1:0] m;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cal_mask = '0; chk_en = 1'b0;
    cyc = 0; n_chk = 0; n_pass = 0; done_cyc = -1; start_cyc = 0;
    mdl_busy = 1'b0; abort_pend = 1'b0; mdl_trim = {NUM_CH{6'h20}}; mdl_sat = '0;
    for (int k = 0; k < NUM_CH; k++) ideal[k] = 32;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_trim", trim_code, 32'h0082_0820);
    check("reset_flags", {sat_flag, busy, done, cal_en, ch_sel}, 0);

    // All channels converge to an in-range ideal code.
    for (int k = 0; k < NUM_CH; k++) ideal[k] = 'h2B;
    pulse_start(4'b1111, 1'b0);
    wait_idle(600);
    check("full_trim", trim_code, {8'h00, {NUM_CH{6'h2B}}});
    check("full_sat", sat_flag, 0);
    check("full_latency", done_cyc - start_cyc + 1, 417);

    // Nothing selected: only the skip steps and the done cycle.
    pulse_start(4'b0000, 1'b0);
    wait_idle(50);
    check("empty_latency", done_cyc - start_cyc + 1, 5);
    check("empty_trim", trim_code, {8'h00, {NUM_CH{6'h2B}}});

    // Abort part-way through channel 1.
    ideal[0] = 'h11; ideal[1] = 'h07; ideal[2] = 'h30; ideal[3] = 'h3E;
    pulse_start(4'b1111, 1'b0);
    repeat (148) @(negedge clk);
    abort = 1'b1;
    abort_pend = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cyc, -1);
    check("abort_ch0", trim_code[5:0], 'h11);
    check("abort_ch1", trim_code[11:6], 'h2B);

    // start and abort together in IDLE: start is dropped.
    pulse_start(4'b1111, 1'b1);
    repeat (3) @(negedge clk);
    check("start_abort_idle", busy, 0);

    // Comparator stuck high, then stuck low, on channel 0 only.
    do_reset();
    ideal[0] = -1;
    pulse_start(4'b0001, 1'b0);
    wait_idle(200);
    check("stuck1_trim", trim_code, 32'h0082_0800);
    check("stuck1_sat", sat_flag, 4'b0001);
    check("stuck1_latency", done_cyc - start_cyc + 1, SEG + 3 + 1);
    ideal[0] = 255;
    pulse_start(4'b0001, 1'b0);
    wait_idle(200);
    check("stuck0_ch0", trim_code[5:0], 'h3F);
    check("stuck0_sat", sat_flag, 4'b0001);

    // A second start while busy is ignored.
    for (int k = 0; k < NUM_CH; k++) ideal[k] = $urandom_range(0, 63);
    pulse_start(4'b1111, 1'b0);
    repeat (200) @(negedge clk);
    pulse_start(4'b0011, 1'b0);
    wait_idle(600);
    check("restart_latency", done_cyc - start_cyc + 1, 417);

    // Random masks and ideal codes, occasionally out of range.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        case ($urandom_range(0, 5))
          0: ideal[k] = -1;
          1: ideal[k] = 255;
          default: ideal[k] = $urandom_range(0, 63);
        endcase
      end
      m = NUM_CH'($urandom);
      lat_exp = 1;
      for (int k = 0; k < NUM_CH; k++) lat_exp += m[k] ? SEG : 1;
      pulse_start(m, 1'b0);
      wait_idle(600);
      check("rand_latency", done_cyc - start_cyc + 1, lat_exp);
    end

    // Asynchronous reset in the middle of a settle window.
    pulse_start(4'b1111, 1'b0);
    repeat (20) @(negedge clk);
    do_reset();
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
